// File: rtl/onehot_step_decoder.sv
// Registered step counter with a one-hot decode of the count, used for T-state timing
// and registered select strobes. Every output comes straight from a flop.
module onehot_step_decoder #(
    parameter int unsigned AW   = 4,
    parameter int unsigned LAST = 2 ** AW - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [AW-1:0]        A,
    input  logic                 step,
    input  logic                 E,
    output logic [(2**AW)-1:0]   D,
    output logic [AW-1:0]        cnt,
    output logic                 wrap,
    output logic                 err
);

    localparam int unsigned NOUT = 2 ** AW;
    localparam logic [AW-1:0] LASTV = AW'(LAST);

    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NOUT-1:0] d_q, d_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            // Out-of-range loads saturate at the terminal step and flag the attempt.
            if (A > LASTV) begin
                cnt_d = LASTV;
                err_d = 1'b1;
            end else begin
                cnt_d = A;
            end
        end else if (step) begin
            if (cnt_q == LASTV) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Decode the next count so D and cnt change on the same edge.
    always_comb begin
        d_d = '0;
        if (E) begin
            d_d[cnt_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            d_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign cnt  = cnt_q;
    assign D    = d_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_onehot_step_decoder.sv
// Self-checking bench: three configurations (AW=4/LAST=15, AW=3/LAST=4, AW=2/LAST=0)
// share one command stream and are compared against an integer reference model.
module tb_onehot_step_decoder;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        load;
    logic        step;
    logic        e;
    logic [3:0]  a4;

    logic [15:0] d0;
    logic [7:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [1:0]  cnt2;
    logic        wrap0, wrap1, wrap2;
    logic        err0, err1, err2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_cnt[3];
    bit m_wrap[3];
    bit m_err[3];
    bit m_e;
    int last_v[3] = '{15, 4, 0};
    int aw_v[3]   = '{4, 3, 2};

    onehot_step_decoder #(.AW(4), .LAST(15)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .A(a4), .step(step), .E(e),
        .D(d0), .cnt(cnt0), .wrap(wrap0), .err(err0)
    );

    onehot_step_decoder #(.AW(3), .LAST(4)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .A(a4[2:0]), .step(step), .E(e),
        .D(d1), .cnt(cnt1), .wrap(wrap1), .err(err1)
    );

    onehot_step_decoder #(.AW(2), .LAST(0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .A(a4[1:0]), .step(step), .E(e),
        .D(d2), .cnt(cnt2), .wrap(wrap2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
        m_e = 1'b0;
    endtask

    // Apply the command that was present at the edge just taken.
    task automatic model_edge();
        int av;
        for (int i = 0; i < 3; i++) begin
            av = int'(a4) % (1 << aw_v[i]);
            m_wrap[i] = 1'b0;
            if (clr) begin
                m_cnt[i] = 0;
            end else if (load) begin
                if (av > last_v[i]) begin
                    m_cnt[i] = last_v[i];
                    m_err[i] = 1'b1;
                end else begin
                    m_cnt[i] = av;
                end
            end else if (step) begin
                m_wrap[i] = (m_cnt[i] == last_v[i]);
                m_cnt[i]  = (m_cnt[i] + 1) % (last_v[i] + 1);
            end
        end
        m_e = e;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] dobs[3];
        logic [31:0] cobs[3];
        logic [31:0] wobs[3];
        logic [31:0] eobs[3];
        logic [31:0] dexp;
        dobs[0] = 32'(d0);   dobs[1] = 32'(d1);   dobs[2] = 32'(d2);
        cobs[0] = 32'(cnt0); cobs[1] = 32'(cnt1); cobs[2] = 32'(cnt2);
        wobs[0] = 32'(wrap0); wobs[1] = 32'(wrap1); wobs[2] = 32'(wrap2);
        eobs[0] = 32'(err0); eobs[1] = 32'(err1); eobs[2] = 32'(err2);
        for (int i = 0; i < 3; i++) begin
            dexp = m_e ? (32'd1 << m_cnt[i]) : 32'd0;
            check_eq($sformatf("%s u%0d D", tag, i), dobs[i], dexp);
            check_eq($sformatf("%s u%0d cnt", tag, i), cobs[i], 32'(m_cnt[i]));
            check_eq($sformatf("%s u%0d wrap", tag, i), wobs[i], 32'(m_wrap[i]));
            check_eq($sformatf("%s u%0d err", tag, i), eobs[i], 32'(m_err[i]));
        end
    endtask

    task automatic do_cycle(input logic c, input logic l, input logic s, input logic en,
                            input logic [3:0] a, input string tag);
        clr  = c;
        load = l;
        step = s;
        e    = en;
        a4   = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset a couple of ns into the cycle, held across one edge.
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all({tag, " async"});
        @(posedge clk);
        #1;
        compare_all({tag, " held"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; step = 1'b0; e = 1'b0; a4 = '0;
        model_reset();
        #1;
        compare_all("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset with cnt=9 and E=1, then first edge shows step 0.
        do_cycle(0, 1, 0, 1, 4'h9, "load9");
        mid_cycle_reset("rst9");
        do_cycle(0, 0, 0, 1, 4'h0, "first");

        // Full walk of 17 steps.
        for (int k = 0; k < 17; k++) begin
            do_cycle(0, 0, 1, 1, 4'h0, $sformatf("walk%0d", k));
        end

        // Direct decode with output enable toggled.
        do_cycle(0, 1, 0, 1, 4'hA, "decA");
        do_cycle(0, 0, 0, 0, 4'h0, "decA_off");
        do_cycle(0, 0, 0, 1, 4'h0, "decA_on");

        // Illegal load then clear; err stays sticky.
        do_cycle(0, 1, 0, 1, 4'h6, "ill6");
        do_cycle(1, 0, 0, 1, 4'h0, "clr");
        do_cycle(0, 0, 1, 1, 4'h0, "post_clr");

        // Priority cases.
        do_cycle(1, 1, 1, 1, 4'h3, "clr_ld_st");
        do_cycle(0, 1, 0, 1, 4'hF, "ld_last");
        do_cycle(0, 1, 1, 1, 4'h2, "ld_st");

        mid_cycle_reset("rst2");

        // Randomized commands with occasional asynchronous resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_cycle_reset($sformatf("rnd_rst%0d", k));
            end else begin
                do_cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                         1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) != 0),
                         4'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
